// File: rtl/mul_arb_pkg.sv
// mul_arb_pkg
//   Shared definitions for the multiplier arbiter:
//   - state_t   : arbiter FSM states (2-bit encoding)
//   - DEF_N, DEF_W, DEF_MAX_WAIT : default requester count, operand width, WAIT budget
//   - cnt_width : width of the WAIT-cycle counter for a given budget
package mul_arb_pkg;

   localparam int DEF_N        = 4;
   localparam int DEF_W        = 16;
   localparam int DEF_MAX_WAIT = 1024;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   // The counter never holds more than MAX_WAIT-1, so clog2 bits suffice.
   function automatic int cnt_width(input int max_wait);
      return (max_wait > 2) ? $clog2(max_wait) : 1;
   endfunction

endpackage

// File: rtl/mul_rr_pick.sv
// mul_rr_pick
//   Combinational rotating-priority picker: selects the first asserted request
//   at or after ptr, wrapping modulo N.
//   Ports:
//     req    in  N   request levels
//     ptr    in  IW  highest-priority index
//     hit    out 1   some request is asserted
//     idx    out IW  index of the chosen request
//     onehot out N   one-hot form of idx (all zero when no hit)
module mul_rr_pick
   import mul_arb_pkg::*;
#(
   parameter int N  = DEF_N,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          hit,
   output logic [IW-1:0] idx,
   output logic [N-1:0]  onehot
);

   logic [IW-1:0] pos;

   always_comb begin
      hit = 1'b0;
      idx = '0;
      pos = '0;
      // Scan from the farthest offset down so the nearest request to ptr wins.
      for (int k = N - 1; k >= 0; k--) begin
         pos = IW'((int'(ptr) + k) % N);
         if (req[pos]) begin
            hit = 1'b1;
            idx = pos;
         end
      end
      onehot = hit ? (N'(1) << idx) : '0;
   end

endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter
//   Round-robin scheduler sharing one repeated-addition multiplier between N
//   requesters. Only IDLE arbitrates; a job runs IDLE -> ISSUE -> WAIT -> DRAIN,
//   or IDLE -> DRAIN directly when an operand is zero (multiplier not started).
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     req [N]           request levels; a_in/b_in packed W bits per requester
//     gnt [N]           one-cycle accept pulse
//     rsp_valid [N]     one-cycle response pulse; rsp_p/rsp_err qualify it
//     rsp_p [2W]        product (held until the next response), 0 on abort
//     rsp_err           job aborted by WAIT timeout
//     mul_start         one-cycle multiplier launch
//     mul_a, mul_b [W]  operands, held from arbitration until the next one
//     mul_clr           returns multiplier controller to idle (DRAIN and reset)
//     mul_done, mul_p   multiplier status (sticky) and product
module mul_arbiter
   import mul_arb_pkg::*;
#(
   parameter int N        = DEF_N,
   parameter int W        = DEF_W,
   parameter int MAX_WAIT = DEF_MAX_WAIT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic [N*W-1:0]   a_in,
   input  logic [N*W-1:0]   b_in,
   output logic [N-1:0]     gnt,
   output logic [N-1:0]     rsp_valid,
   output logic [2*W-1:0]   rsp_p,
   output logic             rsp_err,
   output logic             mul_start,
   output logic [W-1:0]     mul_a,
   output logic [W-1:0]     mul_b,
   output logic             mul_clr,
   input  logic             mul_done,
   input  logic [2*W-1:0]   mul_p
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = cnt_width(MAX_WAIT);
   localparam logic [CW-1:0] CNT_LIMIT = CW'(MAX_WAIT - 1);

   state_t        state_reg, state_next;
   logic [IW-1:0] cur_reg, cur_next;
   logic [IW-1:0] ptr_reg, ptr_next;
   logic [CW-1:0] cnt_reg, cnt_next, cnt_inc;

   logic [N-1:0]   gnt_next, rsp_valid_next;
   logic [2*W-1:0] rsp_p_next;
   logic           rsp_err_next, mul_start_next, mul_clr_next;
   logic [W-1:0]   mul_a_next, mul_b_next;

   logic          pick_hit;
   logic [IW-1:0] pick_idx;
   logic [N-1:0]  pick_onehot;
   logic          pick_zero;

   // Unpacked operand views so the chosen requester can be indexed directly.
   logic [W-1:0] a_arr [N];
   logic [W-1:0] b_arr [N];

   for (genvar gi = 0; gi < N; gi++) begin : g_unpack
      assign a_arr[gi] = a_in[gi*W +: W];
      assign b_arr[gi] = b_in[gi*W +: W];
   end

   mul_rr_pick #(.N(N), .IW(IW)) u_pick (
      .req    (req),
      .ptr    (ptr_reg),
      .hit    (pick_hit),
      .idx    (pick_idx),
      .onehot (pick_onehot)
   );

   assign pick_zero = (a_arr[pick_idx] == '0) || (b_arr[pick_idx] == '0);
   assign cnt_inc   = cnt_reg + 1'b1;

   always_comb begin
      state_next     = state_reg;
      cur_next       = cur_reg;
      ptr_next       = ptr_reg;
      cnt_next       = cnt_reg;
      gnt_next       = '0;
      rsp_valid_next = '0;
      rsp_p_next     = rsp_p;
      rsp_err_next   = 1'b0;
      mul_start_next = 1'b0;
      mul_clr_next   = 1'b0;
      mul_a_next     = mul_a;
      mul_b_next     = mul_b;

      unique case (state_reg)
         IDLE: begin
            if (pick_hit) begin
               cur_next   = pick_idx;
               mul_a_next = a_arr[pick_idx];
               mul_b_next = b_arr[pick_idx];
               gnt_next   = pick_onehot;
               if (pick_zero) begin
                  // Product is known to be 0: respond straight from DRAIN.
                  state_next     = DRAIN;
                  rsp_valid_next = pick_onehot;
                  rsp_p_next     = '0;
                  mul_clr_next   = 1'b1;
               end else begin
                  state_next     = ISSUE;
                  mul_start_next = 1'b1;
               end
            end
         end
         ISSUE: begin
            // mul_done is deliberately not looked at here.
            cnt_next   = '0;
            state_next = WAIT;
         end
         WAIT: begin
            if (mul_done) begin
               // Done wins over a timeout landing on the same edge.
               rsp_p_next     = mul_p;
               rsp_valid_next = N'(1) << cur_reg;
               mul_clr_next   = 1'b1;
               state_next     = DRAIN;
            end else if (cnt_inc == CNT_LIMIT) begin
               // This edge would bring the count to MAX_WAIT-1: abort the job.
               // The error flag is carried straight into the rsp_err register.
               rsp_p_next     = '0;
               rsp_err_next   = 1'b1;
               rsp_valid_next = N'(1) << cur_reg;
               mul_clr_next   = 1'b1;
               state_next     = DRAIN;
            end else begin
               cnt_next = cnt_inc;
            end
         end
         DRAIN: begin
            ptr_next   = (cur_reg == IW'(N - 1)) ? '0 : cur_reg + 1'b1;
            cnt_next   = '0;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         cur_reg   <= '0;
         ptr_reg   <= '0;
         cnt_reg   <= '0;
         gnt       <= '0;
         rsp_valid <= '0;
         rsp_p     <= '0;
         rsp_err   <= 1'b0;
         mul_start <= 1'b0;
         mul_a     <= '0;
         mul_b     <= '0;
         mul_clr   <= 1'b1;   // a reset mid-job must also idle the multiplier
      end else begin
         state_reg <= state_next;
         cur_reg   <= cur_next;
         ptr_reg   <= ptr_next;
         cnt_reg   <= cnt_next;
         gnt       <= gnt_next;
         rsp_valid <= rsp_valid_next;
         rsp_p     <= rsp_p_next;
         rsp_err   <= rsp_err_next;
         mul_start <= mul_start_next;
         mul_a     <= mul_a_next;
         mul_b     <= mul_b_next;
         mul_clr   <= mul_clr_next;
      end
   end

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter
//   Self-checking bench for mul_arbiter with a behavioural multiplier whose
//   done latency is programmable, and a job-level reference model (round-robin
//   choice, product, error flag and response latency) in the monitor.
module tb_mul_arbiter;
   import mul_arb_pkg::*;

   localparam int N        = 4;
   localparam int W        = 16;
   localparam int MAX_WAIT = 16;
   localparam int IW       = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     req;
   logic [N*W-1:0]   a_in, b_in;
   logic [N-1:0]     gnt, rsp_valid;
   logic [2*W-1:0]   rsp_p;
   logic             rsp_err, mul_start, mul_clr;
   logic [W-1:0]     mul_a, mul_b;
   logic             mul_done;
   logic [2*W-1:0]   mul_p;

   always #5 clk = ~clk;

   mul_arbiter #(.N(N), .W(W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
      .gnt(gnt), .rsp_valid(rsp_valid), .rsp_p(rsp_p), .rsp_err(rsp_err),
      .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_clr(mul_clr),
      .mul_done(mul_done), .mul_p(mul_p)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   // ---------------- stimulus state ----------------
   logic [N-1:0] req_v;
   logic [W-1:0] a_v [N];
   logic [W-1:0] b_v [N];
   int           lat_cfg;   // multiplier done latency in cycles after mul_start is seen
   bit           mon_en;

   task automatic drive();
      req = req_v;
      for (int i = 0; i < N; i++) begin
         a_in[i*W +: W] = a_v[i];
         b_in[i*W +: W] = b_v[i];
      end
   endtask

   task automatic new_ops(input int i);
      case ($urandom_range(0, 9))
         0:       begin a_v[i] = '0;           b_v[i] = W'($urandom()); end
         1:       begin a_v[i] = W'($urandom()); b_v[i] = '0;           end
         2:       begin a_v[i] = '1;           b_v[i] = '1;           end
         default: begin a_v[i] = W'($urandom()); b_v[i] = W'($urandom()); end
      endcase
   endtask

   // ---------------- multiplier model ----------------
   int m_k;
   bit m_act;
   initial begin
      mul_done = 1'b0;
      mul_p    = '0;
      m_k      = 0;
      m_act    = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (mul_clr) begin
            mul_done = 1'b0;
            m_act    = 1'b0;
         end else if (mul_start) begin
            if (lat_cfg == 0) begin
               mul_done = 1'b1;
               mul_p    = (2*W)'(mul_a) * (2*W)'(mul_b);
            end else begin
               m_act = 1'b1;
               m_k   = lat_cfg;
            end
         end else if (m_act) begin
            m_k--;
            if (m_k == 0) begin
               m_act    = 1'b0;
               mul_done = 1'b1;
               mul_p    = (2*W)'(mul_a) * (2*W)'(mul_b);
            end
         end
         if (!mul_done) mul_p = (2*W)'($urandom());   // noise until the product is valid
      end
   end

   // ---------------- monitor / reference model ----------------
   logic [N-1:0]   req_s;
   logic [W-1:0]   a_s [N];
   logic [W-1:0]   b_s [N];
   int             cyc = 0;
   int             ref_ptr = 0;
   bit             outst = 1'b0;
   int             mk_idx, e_lat, g_cyc, n_jobs = 0;
   logic [IW-1:0]  sel;
   logic [N-1:0]   e_oh;
   logic [W-1:0]   e_a, e_b;
   logic [2*W-1:0] e_p, last_p = '0;
   bit             e_err, e_zero;

   always @(negedge clk) begin
      if (!mon_en) begin
         outst   = 1'b0;
         ref_ptr = 0;
         last_p  = '0;
      end else begin
         if (outst) begin
            check("hold_a", 64'(mul_a), 64'(e_a));
            check("hold_b", 64'(mul_b), 64'(e_b));
         end
         if (gnt != '0 || mul_start) begin
            check("gnt_busy", 64'(outst), 64'(0));
            mk_idx = -1;
            for (int k = N - 1; k >= 0; k--) begin
               sel = IW'((ref_ptr + k) % N);
               if (req_s[sel]) mk_idx = (ref_ptr + k) % N;
            end
            if (mk_idx < 0) begin
               check("gnt_noreq", 64'(gnt), 64'(0));
            end else begin
               sel    = IW'(mk_idx);
               e_oh   = N'(1) << sel;
               check("gnt_idx", 64'(gnt), 64'(e_oh));
               e_a    = a_s[sel];
               e_b    = b_s[sel];
               e_zero = (e_a == '0) || (e_b == '0);
               check("mul_a", 64'(mul_a), 64'(e_a));
               check("mul_b", 64'(mul_b), 64'(e_b));
               check("mul_start", 64'(mul_start), 64'(!e_zero));
               e_err = !e_zero && (lat_cfg > MAX_WAIT - 1);
               e_p   = (e_zero || e_err) ? '0 : (2*W)'(e_a) * (2*W)'(e_b);
               if (e_zero)     e_lat = 0;
               else if (e_err) e_lat = MAX_WAIT;
               else            e_lat = ((lat_cfg < 1) ? 1 : lat_cfg) + 1;
               g_cyc = cyc;
               outst = 1'b1;
            end
         end
         if (rsp_valid != '0) begin
            if (!outst) begin
               check("rsp_spurious", 64'(rsp_valid), 64'(0));
            end else begin
               check("rsp_idx", 64'(rsp_valid), 64'(e_oh));
               check("rsp_p",   64'(rsp_p),     64'(e_p));
               check("rsp_err", 64'(rsp_err),   64'(e_err));
               check("rsp_clr", 64'(mul_clr),   64'(1));
               check("rsp_lat", 64'(cyc - g_cyc), 64'(e_lat));
               $display("job %0d: req %0d a=%h b=%h p=%h err=%0b lat=%0d",
                        n_jobs, mk_idx, e_a, e_b, rsp_p, rsp_err, cyc - g_cyc);
               ref_ptr = (mk_idx + 1) % N;
               outst   = 1'b0;
               n_jobs++;
            end
            last_p = rsp_p;
         end else begin
            if (outst) begin
               check("rsp_hold", 64'(rsp_p), 64'(last_p));
               check("err_idle", 64'(rsp_err), 64'(0));
            end
            if (mul_clr) check("clr_stray", 64'(mul_clr), 64'(0));
            if (outst && (cyc - g_cyc) > MAX_WAIT + 4) begin
               check("rsp_timeout", 64'(0), 64'(1));
               outst = 1'b0;
            end
         end
      end
      req_s = req;
      for (int i = 0; i < N; i++) begin
         a_s[i] = a_in[i*W +: W];
         b_s[i] = b_in[i*W +: W];
      end
      cyc++;
   end

   // ---------------- directed helpers ----------------
   task automatic single(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input int lat);
      bit seen;
      lat_cfg = lat;
      req_v[i] = 1'b1;
      a_v[i]   = a;
      b_v[i]   = b;
      drive();
      seen = 1'b0;
      for (int c = 0; c < 30 && !seen; c++) begin
         @(posedge clk); #1;
         if (gnt[i]) seen = 1'b1;
      end
      check("single_gnt_seen", 64'(seen), 64'(1));
      req_v[i] = 1'b0;
      drive();
      seen = rsp_valid[i];
      for (int c = 0; c < 40 && !seen; c++) begin
         @(posedge clk); #1;
         if (rsp_valid[i]) seen = 1'b1;
      end
      check("single_rsp_seen", 64'(seen), 64'(1));
      @(posedge clk); #1;
   endtask

   task automatic run(input int cycles, input bit cont);
      for (int c = 0; c < cycles; c++) begin
         @(posedge clk); #1;
         if (rsp_valid != '0) lat_cfg = $urandom_range(0, MAX_WAIT + 1);
         for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
               if (cont || $urandom_range(0, 1) == 1) begin
                  req_v[i] = 1'b1;
                  new_ops(i);
               end else begin
                  req_v[i] = 1'b0;
               end
            end else if (!cont && !req_v[i] && $urandom_range(0, 3) == 0) begin
               req_v[i] = 1'b1;
               new_ops(i);
            end
         end
         drive();
      end
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_gnt"},       64'(gnt),       64'(0));
      check({pfx, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
      check({pfx, "_rsp_p"},     64'(rsp_p),     64'(0));
      check({pfx, "_rsp_err"},   64'(rsp_err),   64'(0));
      check({pfx, "_mul_start"}, 64'(mul_start), 64'(0));
      check({pfx, "_mul_a"},     64'(mul_a),     64'(0));
      check({pfx, "_mul_b"},     64'(mul_b),     64'(0));
      check({pfx, "_mul_clr"},   64'(mul_clr),   64'(1));
   endtask

   initial begin
      bit seen;
      mon_en  = 1'b0;
      rst     = 1'b1;
      req_v   = '0;
      lat_cfg = 8;
      for (int i = 0; i < N; i++) begin a_v[i] = '0; b_v[i] = '0; end
      drive();
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("rst");
      rst = 1'b0;
      @(posedge clk); #1;
      check("rst_release_clr", 64'(mul_clr), 64'(0));
      mon_en = 1'b1;

      single(2, 16'd7, 16'd5, 8);          // plain job
      single(1, 16'd9, 16'd0, 8);          // zero operand
      single(0, 16'd3, 16'd3, 1000);       // timeout
      single(0, 16'd5, 16'd6, 4);          // served normally afterwards
      single(3, 16'hFFFF, 16'hFFFF, 15);   // done on the timeout edge
      single(3, 16'hFFFF, 16'hFFFF, 16);   // done one cycle too late
      single(2, 16'd11, 16'd2, 0);         // done already high in ISSUE

      // Reset in the middle of WAIT.
      lat_cfg  = 1000;
      req_v[2] = 1'b1; a_v[2] = 16'd11; b_v[2] = 16'd13;
      drive();
      seen = 1'b0;
      for (int c = 0; c < 30 && !seen; c++) begin
         @(posedge clk); #1;
         if (gnt[2]) seen = 1'b1;
      end
      check("rw_gnt_seen", 64'(seen), 64'(1));
      mon_en   = 1'b0;
      req_v[2] = 1'b0;
      drive();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs("rw");
      rst = 1'b0;
      @(posedge clk); #1;
      mon_en = 1'b1;
      single(3, 16'd3, 16'd4, 5);

      // All requesters continuously busy, then random traffic.
      lat_cfg = $urandom_range(0, MAX_WAIT + 1);
      for (int i = 0; i < N; i++) begin req_v[i] = 1'b1; new_ops(i); end
      drive();
      run(300, 1'b1);
      run(500, 1'b0);
      req_v = '0;
      drive();
      repeat (40) @(posedge clk);
      #1;
      check("jobs_done_min", 64'(n_jobs > 20), 64'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Round-robin scheduler that shares one repeated-addition multiplier datapath (and its controller) between N requesters. It accepts operand pairs over a per-requester req/gnt handshake and launches the shared unit with a one-cycle start. It then waits for done and returns the product to the granted requester with a one-cycle valid pulse. It sits between the client blocks and the multiplier's start/done/operand ports, and owns the multiplier's clear.

## Interface
- N, 4: number of requesters (2..8)
- W, 16: operand width; product is 2W
- MAX_WAIT, 1024: cycles allowed in WAIT before the job is aborted
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  N  per-requester request level
- a_in  in  N*W  operand A, requester i at bits [i*W +: W]
- b_in  in  N*W  operand B, same packing
- gnt  out  N  one-hot, one-cycle pulse: request accepted
- rsp_valid  out  N  one-hot, one-cycle pulse: rsp_p/rsp_err valid for that requester
- rsp_p  out  2W  product, held until next rsp_valid
- rsp_err  out  1  qualifies rsp_valid: job aborted by timeout, rsp_p = 0
- mul_start  out  1  one-cycle start to multiplier controller
- mul_a, mul_b  out  W  operands to multiplier datapath, held stable from ISSUE through WAIT
- mul_clr  out  1  returns multiplier controller to its idle state
- mul_done  in  1  multiplier finished (level, sticky until mul_clr)
- mul_p  in  2W  multiplier product

## Operation
- States: IDLE, ISSUE, WAIT, DRAIN.
- IDLE: if any req is high, pick the first requester at or after the round-robin pointer ptr, modulo N. Latch its operands into mul_a/mul_b and its index into cur.
  - If the latched b is 0 or a is 0, go to DRAIN with product 0; the multiplier is not started.
  - Otherwise go to ISSUE.
- ISSUE: gnt[cur]=1 and mul_start=1 for exactly one cycle, then go to WAIT. On the zero-operand path, gnt[cur] pulses in the DRAIN cycle instead.
- WAIT: a counter increments every cycle.
  - mul_done=1: capture mul_p into rsp_p, go to DRAIN.
  - Counter reaches MAX_WAIT-1 with no done: rsp_p=0, set error flag, go to DRAIN.
- DRAIN: rsp_valid[cur]=1, rsp_err=flag, mul_clr=1 for one cycle. Set ptr=(cur+1) mod N, clear flag and counter, go to IDLE.
- Requesters hold req, a_in and b_in stable until their gnt. req still high in the cycle after gnt is a new request.
- Requests that change while not in IDLE are ignored; only IDLE arbitrates.
- Width: mul_p is taken as-is, with no truncation or saturation. The product of two W-bit unsigned operands fits in 2W.

## Timing
- Reset (rst high at an edge):
  - State IDLE, ptr=0, cur=0, counter=0.
  - gnt, rsp_valid, rsp_p, rsp_err, mul_start, mul_a, mul_b are 0.
  - mul_clr=1 on every cycle rst is sampled high, so a reset mid-WAIT also clears the multiplier.
  - The first arbitration happens on the first edge with rst low.
- All outputs are registered.
- Latency from req seen in IDLE:
  - gnt/mul_start: +1 cycle.
  - rsp_valid: +1 cycle after the edge where mul_done is sampled high.
  - Zero-operand path: gnt and rsp_valid together, 1 cycle after the request.
- Back-to-back: the minimum period between grants is 3 cycles plus the multiplier busy time, because DRAIN returns to IDLE before the next arbitration.
- mul_done high in ISSUE is ignored; only WAIT samples it.
- mul_done and the timeout in the same cycle: done wins, rsp_err=0.
- Fairness: with all N requesting continuously, grants go ptr, ptr+1, … with no requester granted twice before every other active one.

## Structure
- Package mul_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, DRAIN, 2-bit encoding);
  - the default W/N/MAX_WAIT constants;
  - a function for the counter width, clog2(MAX_WAIT).
- Sub-module mul_rr_pick: combinational rotating-priority picker. Inputs req[N] and ptr; outputs hit, idx and a one-hot grant.
- The FSM, operand muxing, counter and response registers stay in mul_arbiter.

## Test plan
- Single request: req[2]=1, a=7, b=5, with a multiplier model asserting done 8 cycles after start.
  - gnt[2] and mul_start pulse once, mul_a=7, mul_b=5.
  - rsp_valid[2]=1, rsp_p=35, rsp_err=0, mul_clr pulse.
- All four requesting continuously from reset, ptr=0.
  - Grant order is 0,1,2,3,0,…
  - Exactly one mul_start per grant; no gnt while state is not IDLE.
- Zero operand: req[1]=1, a=9, b=0.
  - gnt[1] and rsp_valid[1] pulse in the same cycle, rsp_p=0.
  - mul_start never asserted.
- Timeout: MAX_WAIT=16, multiplier model never asserts done.
  - rsp_valid and rsp_err pulse 16 cycles after mul_start, rsp_p=0, mul_clr=1.
  - The next request is served normally.
- Reset mid-WAIT: rst asserted 3 cycles after mul_start.
  - The next cycle has all outputs 0 except mul_clr=1.
  - After release, req[3] with a=3, b=4 gives rsp_p=12 to requester 3.
- Done coincident with timeout cycle, max operands a=b=16'hFFFF.
  - rsp_p=32'hFFFE0001, rsp_err=0.
